// File: rtl/wishbone_master.sv
// Wishbone classic single-cycle initiator.
// Converts one valid/ready command into one registered Wishbone read or write.
// Returns a one-cycle response pulse. Waits for the target to release ack before
// it accepts the next command. BUS and RELEASE waits are bounded by TIMEOUT.
module wishbone_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // command / response port
   // Handshake: a command transfers on a rising clk_i edge where cmd_valid_i and
   // cmd_ready_o are both 1; rsp_valid_o is a one-cycle pulse with no back-pressure.
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              bus_fault_o,
   // Wishbone initiator
   output logic              cyc_o,
   output logic              stb_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ack_i,
   // debug view of the FSM state
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUS     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // A timeout of 0 disables the abort, but the counter still needs at least one bit.
   localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit               TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // The command port is ready only in IDLE, and never while reset is asserted.
   assign cmd_ready_o = (state == IDLE) & rst_i;
   assign state_o     = state;

   // Main FSM: every Wishbone and response output is a register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         cyc_o       <= 1'b0;
         stb_o       <= 1'b0;
         we_o        <= 1'b0;
         addr_o      <= '0;
         data_o      <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_data_o  <= '0;
         bus_fault_o <= 1'b0;
      end else begin
         rsp_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  we_o   <= cmd_we_i;
                  addr_o <= cmd_addr_i;
                  data_o <= cmd_data_i;
                  cyc_o  <= 1'b1;
                  stb_o  <= 1'b1;
                  cnt    <= '0;
                  state  <= BUS;
               end
            end
            BUS: begin
               if (ack_i) begin
                  // An ack on the timeout edge still completes normally.
                  cyc_o       <= 1'b0;
                  stb_o       <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  if (!we_o) begin
                     rsp_data_o <= data_i;
                  end
                  cnt   <= '0;
                  state <= RELEASE;
               end else if (TO_EN && (cnt == CNT_LAST)) begin
                  cyc_o       <= 1'b0;
                  stb_o       <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  rsp_data_o  <= '0;
                  cnt         <= '0;
                  state       <= RELEASE;
               end else if (cnt != CNT_SAT) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               // The target holds ack until cyc/stb drop. Wait for it to let go.
               if (!ack_i) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (TO_EN && (cnt == CNT_LAST)) begin
                  bus_fault_o <= 1'b1;
                  cnt         <= '0;
                  state       <= IDLE;
               end else if (cnt != CNT_SAT) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               cyc_o <= 1'b0;
               stb_o <= 1'b0;
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_master.sv
// Self-checking bench for wishbone_master. A target model answers with a configurable
// ack delay and ack hold time. Response contents are predicted into a scoreboard queue,
// and cycle lengths are predicted from the timeout rules.
module tb_wishbone_master;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TO     = 8;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic              cmd_we_i;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [DATA_W-1:0] cmd_data_i;
   logic              rsp_valid_o;
   logic [DATA_W-1:0] rsp_data_o;
   logic              rsp_err_o;
   logic              bus_fault_o;
   logic              cyc_o;
   logic              stb_o;
   logic              we_o;
   logic [ADDR_W-1:0] addr_o;
   logic [DATA_W-1:0] data_o;
   logic [DATA_W-1:0] data_i;
   logic              ack_i;
   logic [1:0]        state_o;

   wishbone_master #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TO)
   ) u_dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_we_i   (cmd_we_i),
      .cmd_addr_i (cmd_addr_i),
      .cmd_data_i (cmd_data_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_data_o (rsp_data_o),
      .rsp_err_o  (rsp_err_o),
      .bus_fault_o(bus_fault_o),
      .cyc_o      (cyc_o),
      .stb_o      (stb_o),
      .we_o       (we_o),
      .addr_o     (addr_o),
      .data_o     (data_o),
      .data_i     (data_i),
      .ack_i      (ack_i),
      .state_o    (state_o)
   );

   // clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard: {err, data} of every expected response, in order
   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W:0]   mon_exp;
   logic [DATA_W-1:0] last_data;
   int                rsp_seen = 0;
   int                rsp_exp  = 0;

   always @(negedge clk_i) begin
      if (rst_i && rsp_valid_o) begin
         rsp_seen++;
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("rsp_err", rsp_err_o, mon_exp[DATA_W]);
            check("rsp_data", rsp_data_o, mon_exp[DATA_W-1:0]);
         end
      end
   end

   // target model: ack after slv_delay cycles of cyc, hold ack slv_hold cycles after drop
   int                slv_delay    = 0;
   int                slv_hold     = 0;
   bit                slv_never    = 1'b0;
   bit                slv_stuck    = 1'b0;
   logic [DATA_W-1:0] slv_rdata    = '0;
   int                slv_bus_cnt  = 0;
   int                slv_hold_cnt = 0;

   initial begin
      ack_i  = 1'b0;
      data_i = '0;
   end

   always @(negedge clk_i) begin
      if (slv_stuck) begin
         ack_i  = 1'b1;
         data_i = slv_rdata;
      end else if (cyc_o && stb_o) begin
         if (!slv_never && slv_bus_cnt == slv_delay) begin
            ack_i  = 1'b1;
            data_i = slv_rdata;
         end
         slv_bus_cnt++;
         slv_hold_cnt = 0;
      end else begin
         slv_bus_cnt = 0;
         if (ack_i) begin
            if (slv_hold_cnt < slv_hold) slv_hold_cnt++;
            else ack_i = 1'b0;
         end
      end
   end

   // driver: issue one command and check its Wishbone cycle and release timing
   task automatic do_cmd(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                         input int delay, input int hold, input bit never, input bit keep_valid);
      int                n;
      int                cyc_cnt;
      int                rel_cnt;
      bit                to;
      logic [DATA_W-1:0] exp_data;
      n = 0;
      while (!cmd_ready_o && n < 4 * TO) begin
         @(negedge clk_i);
         n++;
      end
      check("ready_wait", cmd_ready_o, 1);
      slv_delay   = delay;
      slv_hold    = hold;
      slv_never   = never;
      slv_rdata   = rdata;
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_addr_i  = addr;
      cmd_data_i  = wdata;
      to       = !slv_stuck && (never || delay >= TO);
      exp_data = to ? '0 : (we ? last_data : rdata);
      last_data = exp_data;
      exp_q.push_back({to, exp_data});
      rsp_exp++;
      @(negedge clk_i);
      if (!keep_valid) cmd_valid_i = 1'b0;
      cyc_cnt = 0;
      while (cyc_o && cyc_cnt < TO + 4) begin
         check("stb_o", stb_o, 1);
         check("we_o", we_o, we);
         check("addr_o", addr_o, addr);
         check("data_o", data_o, wdata);
         check("rsp_early", rsp_valid_o, 0);
         cyc_cnt++;
         @(negedge clk_i);
      end
      check("cyc_len", cyc_cnt, slv_stuck ? 1 : (to ? TO : delay + 1));
      check("rsp_pulse", rsp_valid_o, 1);
      rel_cnt = 0;
      while (!cmd_ready_o && rel_cnt < TO + 4) begin
         check("cyc_in_release", cyc_o, 0);
         if (rel_cnt > 0) check("rsp_one_cycle", rsp_valid_o, 0);
         rel_cnt++;
         @(negedge clk_i);
      end
      check("release_len", rel_cnt, slv_stuck ? TO : ((to || hold == 0) ? 1 : hold + 1));
      check("we_kept", we_o, we);
      check("addr_kept", addr_o, addr);
   endtask

   task automatic apply_reset();
      rst_i = 1'b0;
      #1;
      exp_q.delete();
      last_data = '0;
   endtask

   // main sequence
   initial begin
      rst_i       = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_we_i    = 1'b0;
      cmd_addr_i  = '0;
      cmd_data_i  = '0;
      last_data   = '0;
      repeat (3) @(negedge clk_i);
      check("rst_ready", cmd_ready_o, 0);
      check("rst_cyc", cyc_o, 0);
      check("rst_stb", stb_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rsp_data", rsp_data_o, 0);
      check("rst_fault", bus_fault_o, 0);
      check("rst_addr", addr_o, 0);
      check("rst_state", state_o, 0);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("ready_after_rst", cmd_ready_o, 1);

      // directed: read, write, timeout
      do_cmd(1'b0, 32'h10, 32'h0, 32'hA5A5_0001, 1, 0, 1'b0, 1'b0);
      do_cmd(1'b1, 32'h20, 32'hDEAD_BEEF, 32'h1111_2222, 0, 0, 1'b0, 1'b0);
      do_cmd(1'b0, 32'h30, 32'h0, 32'h3333_4444, 0, 0, 1'b1, 1'b0);
      check("fault_clear", bus_fault_o, 0);

      // back-to-back reads with valid held high and ack held one extra cycle
      do_cmd(1'b0, 32'h40, 32'h0, 32'h0000_0040, 0, 1, 1'b0, 1'b1);
      do_cmd(1'b0, 32'h44, 32'h0, 32'h0000_0044, 2, 1, 1'b0, 1'b0);

      // stuck ack: read completes, release times out, fault is sticky until reset
      slv_stuck = 1'b1;
      @(negedge clk_i);
      do_cmd(1'b0, 32'h50, 32'h0, 32'h5555_AAAA, 0, 0, 1'b0, 1'b0);
      check("fault_set", bus_fault_o, 1);
      check("fault_idle", state_o, 0);
      slv_stuck = 1'b0;
      repeat (3) @(negedge clk_i);
      check("fault_sticky", bus_fault_o, 1);
      apply_reset();
      check("fault_reset", bus_fault_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;

      // reset in the middle of a bus cycle
      slv_never   = 1'b1;
      cmd_valid_i = 1'b1;
      cmd_we_i    = 1'b0;
      cmd_addr_i  = 32'h60;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("mid_cyc_high", cyc_o, 1);
      #2;
      apply_reset();
      check("mid_rst_cyc", cyc_o, 0);
      check("mid_rst_stb", stb_o, 0);
      check("mid_rst_rsp", rsp_valid_o, 0);
      check("mid_rst_ready", cmd_ready_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      do_cmd(1'b0, 32'h64, 32'h0, 32'h6464_6464, 1, 0, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 24; i++) begin
         do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                $urandom_range(0, 9), $urandom_range(0, 2),
                ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      end
      cmd_valid_i = 1'b0;
      repeat (4) @(negedge clk_i);

      check("rsp_count", rsp_seen, rsp_exp);
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
